// File: rtl/byte_logic_defs.sv
// Shared opcode constants and FSM state encoding for the byte logic arbiter.
package byte_logic_defs;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter producing a one-hot grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: favour whichever requester was not granted last.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/byte_logic_arbiter.sv
// Arbitrates two requesters onto one bitwise logic unit; IDLE -> EXEC -> RESP.
module byte_logic_arbiter
  import byte_logic_defs::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Handshake: a request transfers when req_valid[i] & req_ready[i] (only in
  // IDLE); a response transfers when rsp_valid & rsp_ready (only in RESP).

  state_t       state, next_state;
  logic [1:0]   grant;
  logic         accept;
  logic [1:0]   op_q;
  logic [W-1:0] a_q, b_q, data_q, result;
  logic         id_q, last_q;

  rr_arb2 u_arb (
    .req   ((state == ST_IDLE) ? req_valid : 2'b00),
    .last  (last_q),
    .grant (grant)
  );

  assign accept    = |grant;
  assign req_ready = grant;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_comb begin
    result = '0;
    case (op_q)
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      OP_XOR:  result = a_q ^ b_q;
      OP_NAND: result = ~(a_q & b_q);
      default: result = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      data_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q   <= grant[1] ? req_op[3:2] : req_op[1:0];
        a_q    <= grant[1] ? req_a[W +: W] : req_a[0 +: W];
        b_q    <= grant[1] ? req_b[W +: W] : req_b[0 +: W];
        id_q   <= grant[1];
        last_q <= grant[1];
      end
      // The result register only moves on the EXEC -> RESP step.
      if (state == ST_EXEC) data_q <= result;
    end
  end

endmodule

// File: tb/tb_byte_logic_arbiter.sv
// Directed bench for byte_logic_arbiter: reset, ops, round-robin, backpressure, mid-flight reset.
module tb_byte_logic_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  byte_logic_arbiter #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: set both requesters' payloads.
  task automatic drive_req(input logic [1:0] v, input logic [1:0] op0, input logic [7:0] a0,
                           input logic [7:0] b0, input logic [1:0] op1, input logic [7:0] a1,
                           input logic [7:0] b1);
    req_valid = v;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1;
    drive_req(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_and();
    @(negedge clk);
    drive_req(2'b01, 2'b00, 8'hF0, 8'h3C, 2'b00, 8'h00, 8'h00);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL basic_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_exec got=busy%b rdy%b vld%b exp=busy1 rdy00 vld0", busy, req_ready, rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL basic_data_hold got=%h exp=00", rsp_data); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 1'b0) begin failures++; $display("FAIL basic_resp got=v%b d%h id%b exp=v1 d30 id0", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=v%b busy%b exp=v0 busy0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    drive_req(2'b11, 2'b01, 8'h0F, 8'h30, 2'b10, 8'hAA, 8'hFF);
    #1;
    // Requester 0 was granted last, so contention now goes to requester 1.
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_first got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'h55 || rsp_id !== 1'b1) begin failures++; $display("FAIL rr_first_resp got=d%h id%b exp=d55 id1", rsp_data, rsp_id); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_second got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'h3F || rsp_id !== 1'b0) begin failures++; $display("FAIL rr_second_resp got=d%h id%b exp=d3F id0", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_ops_req1();
    drive_req(2'b10, 2'b00, 8'h00, 8'h00, 2'b11, 8'hFF, 8'h0F);
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL nand_grant got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'hF0 || rsp_id !== 1'b1) begin failures++; $display("FAIL nand_resp got=d%h id%b exp=dF0 id1", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive_req(2'b01, 2'b10, 8'h3C, 8'h0F, 2'b00, 8'hFF, 8'h81);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h33 || rsp_id !== 1'b0 || req_ready !== 2'b00)
        begin failures++; $display("FAIL bp_hold%0d got=v%b d%h id%b rdy%b exp=v1 d33 id0 rdy00", i, rsp_valid, rsp_data, rsp_id, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_resp_ready got=%b exp=00", req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b01;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'h81 || rsp_id !== 1'b1) begin failures++; $display("FAIL bp_req1_resp got=d%h id%b exp=d81 id1", rsp_data, rsp_id); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_req0_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'h33 || rsp_id !== 1'b0) begin failures++; $display("FAIL bp_req0_resp got=d%h id%b exp=d33 id0", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive_req(2'b01, 2'b00, 8'hFF, 8'hFF, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL rstmid_in_exec got=%0d exp=1", dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 8'h00 || busy !== 1'b0)
      begin failures++; $display("FAIL rstmid_outputs got=rdy%b v%b id%b d%h busy%b exp=all zero", req_ready, rsp_valid, rsp_id, rsp_data, busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_quiet%0d got=v%b busy%b exp=v0 busy0", i, rsp_valid, busy); end
    end
    drive_req(2'b11, 2'b11, 8'h0F, 8'h0F, 2'b00, 8'hFF, 8'hFF);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstmid_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_data !== 8'hF0 || rsp_id !== 1'b0) begin failures++; $display("FAIL rstmid_resp got=d%h id%b exp=dF0 id0", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_single_req1_or();
    int busy_cycles;
    busy_cycles = 0;
    drive_req(2'b10, 2'b00, 8'h00, 8'h00, 2'b01, 8'h81, 8'h18);
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL or_grant got=%b exp=10", req_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 2'b00;
      #1;
      if (busy === 1'b1) busy_cycles++;
      if (i == 1) begin
        checks++; if (rsp_data !== 8'h99 || rsp_id !== 1'b1) begin failures++; $display("FAIL or_resp got=d%h id%b exp=d99 id1", rsp_data, rsp_id); end
      end
    end
    checks++; if (busy_cycles !== 2) begin failures++; $display("FAIL or_busy_cycles got=%0d exp=2", busy_cycles); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_and();
    test_round_robin();
    test_ops_req1();
    test_backpressure();
    test_reset_mid();
    test_single_req1_or();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
